writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_pkg.sv | 14 +
 rtl/wbq_fwd_lookup.sv | 37 +++
 rtl/writeback_queue.sv | 122 ++++++++++++
 tb/tb_writeback_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/writeback_queue_pkg.sv
// Shared CPU package: default widths for the writeback path and the queue entry layout.
package writeback_queue_pkg;

    localparam int BITSIZE_DEF = 32;
    localparam int REGSIZE_DEF = 32;
    localparam int DEPTH_DEF   = 4;
    localparam int RSEL_W_DEF  = $clog2(REGSIZE_DEF);

    typedef struct packed {
        logic [RSEL_W_DEF-1:0]  rd;
        logic [BITSIZE_DEF-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_lookup.sv
// Youngest-match search over the occupied queue entries for one read port.
module wbq_fwd_lookup
    import writeback_queue_pkg::*;
#(
    parameter int BITSIZE = BITSIZE_DEF,
    parameter int RW      = RSEL_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic [DEPTH-1:0][RW-1:0]      i_rd,
    input  logic [DEPTH-1:0][BITSIZE-1:0] i_data,
    input  logic [$clog2(DEPTH)-1:0]      i_head,
    input  logic [$clog2(DEPTH):0]        i_count,
    input  logic [RW-1:0]                 i_sel,
    output logic                          o_hit,
    output logic [BITSIZE-1:0]            o_data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] w_idx;
    logic          w_match;

    // Walk entries oldest to youngest so the last match seen wins
    always_comb begin
        o_hit   = 1'b0;
        o_data  = '0;
        w_idx   = '0;
        w_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx   = i_head + PW'(i);
            w_match = (i < int'(i_count)) && (i_sel != '0) && (i_rd[w_idx] == i_sel);
            o_hit   = o_hit | w_match;
            o_data  = w_match ? i_data[w_idx] : o_data;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load results into one register-file write port,
// with forwarding of pending results to two read ports.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int BITSIZE = BITSIZE_DEF,
    parameter int REGSIZE = REGSIZE_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [$clog2(REGSIZE)-1:0]   alu_rd,
    input  logic [BITSIZE-1:0]           alu_data,
    input  logic                         mem_valid,
    input  logic [$clog2(REGSIZE)-1:0]   mem_rd,
    input  logic [BITSIZE-1:0]           mem_data,
    output logic                         in_ready,
    output logic [$clog2(REGSIZE)-1:0]   WriteSelect,
    output logic [BITSIZE-1:0]           WriteData,
    output logic                         WriteEnable,
    input  logic [$clog2(REGSIZE)-1:0]   ReadSelect1,
    input  logic [$clog2(REGSIZE)-1:0]   ReadSelect2,
    output logic                         Fwd1Hit,
    output logic [BITSIZE-1:0]           Fwd1Data,
    output logic                         Fwd2Hit,
    output logic [BITSIZE-1:0]           Fwd2Data,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow
);

    localparam int RW = $clog2(REGSIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][RW-1:0]      r_rd;
    logic [DEPTH-1:0][BITSIZE-1:0] r_data;
    logic [PW-1:0]                 r_head;
    logic [PW-1:0]                 r_tail;
    logic [CW-1:0]                 r_count;
    logic                          r_overflow;

    logic          w_mem_ok;
    logic          w_alu_ok;
    logic          w_in_ready;
    logic          w_mem_push;
    logic          w_alu_push;
    logic          w_pop;
    logic          w_drop;
    logic [PW-1:0] w_alu_slot;
    logic [CW-1:0] w_npush;

    // The same-cycle pop is deliberately not credited toward acceptance
    assign w_mem_ok   = mem_valid && (mem_rd != '0);
    assign w_alu_ok   = alu_valid && (alu_rd != '0);
    assign w_in_ready = (r_count <= CW'(DEPTH - 2));
    assign w_mem_push = w_in_ready && w_mem_ok;
    assign w_alu_push = w_in_ready && w_alu_ok;
    assign w_pop      = (r_count != '0);
    assign w_drop     = !w_in_ready && (w_mem_ok || w_alu_ok);
    assign w_alu_slot = w_mem_push ? (r_tail + PW'(1)) : r_tail;
    assign w_npush    = CW'(w_mem_push) + CW'(w_alu_push);

    // Pointer, occupancy and sticky overflow state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + w_npush[PW-1:0];
            r_count <= r_count + w_npush - CW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry storage; mem result takes the older slot when both arrive together
    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_rd[r_tail]   <= mem_rd;
            r_data[r_tail] <= mem_data;
        end
        if (w_alu_push) begin
            r_rd[w_alu_slot]   <= alu_rd;
            r_data[w_alu_slot] <= alu_data;
        end
    end

    assign in_ready    = w_in_ready;
    assign WriteEnable = w_pop;
    assign WriteSelect = w_pop ? r_rd[r_head]   : '0;
    assign WriteData   = w_pop ? r_data[r_head] : '0;
    assign empty       = (r_count == '0);
    assign full        = (r_count == CW'(DEPTH));
    assign overflow    = r_overflow;

    wbq_fwd_lookup #(.BITSIZE(BITSIZE), .RW(RW), .DEPTH(DEPTH)) u_fwd1 (
        .i_rd    (r_rd),
        .i_data  (r_data),
        .i_head  (r_head),
        .i_count (r_count),
        .i_sel   (ReadSelect1),
        .o_hit   (Fwd1Hit),
        .o_data  (Fwd1Data)
    );

    wbq_fwd_lookup #(.BITSIZE(BITSIZE), .RW(RW), .DEPTH(DEPTH)) u_fwd2 (
        .i_rd    (r_rd),
        .i_data  (r_data),
        .i_head  (r_head),
        .i_count (r_count),
        .i_sel   (ReadSelect2),
        .o_hit   (Fwd2Hit),
        .o_data  (Fwd2Data)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue at default parameters (DEPTH = 4).
module tb_writeback_queue;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        in_ready;
    logic [4:0]  WriteSelect;
    logic [31:0] WriteData;
    logic        WriteEnable;
    logic [4:0]  ReadSelect1;
    logic [4:0]  ReadSelect2;
    logic        Fwd1Hit;
    logic [31:0] Fwd1Data;
    logic        Fwd2Hit;
    logic [31:0] Fwd2Data;
    logic        empty;
    logic        full;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    writeback_queue dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .in_ready(in_ready),
        .WriteSelect(WriteSelect), .WriteData(WriteData), .WriteEnable(WriteEnable),
        .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2),
        .Fwd1Hit(Fwd1Hit), .Fwd1Data(Fwd1Data), .Fwd2Hit(Fwd2Hit), .Fwd2Data(Fwd2Data),
        .empty(empty), .full(full), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        ReadSelect1 = 5'd0; ReadSelect2 = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        total++; if (WriteEnable !== 1'b0) begin bad++; $display("FAIL reset_we got=%0h exp=0", WriteEnable); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0h exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h exp=0", full); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
        total++; if ({Fwd1Hit, Fwd2Hit} !== 2'b00) begin bad++; $display("FAIL reset_fwd got=%0b exp=00", {Fwd1Hit, Fwd2Hit}); end
    endtask

    task automatic test_single();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        ReadSelect2 = 5'd5;
        #1;
        total++; if (Fwd2Hit !== 1'b0) begin bad++; $display("FAIL fwd_ignores_offer got=%0h exp=0", Fwd2Hit); end
        tick();
        idle();
        total++; if (WriteEnable !== 1'b1) begin bad++; $display("FAIL single_we got=%0h exp=1", WriteEnable); end
        total++; if (WriteSelect !== 5'd5) begin bad++; $display("FAIL single_ws got=%0h exp=5", WriteSelect); end
        total++; if (WriteData !== 32'h11) begin bad++; $display("FAIL single_wd got=%0h exp=11", WriteData); end
        total++; if (Fwd2Hit !== 1'b1 || Fwd2Data !== 32'h11) begin bad++; $display("FAIL fwd_head got=%0h/%0h exp=1/11", Fwd2Hit, Fwd2Data); end
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_drained got=%0h exp=1", empty); end
        total++; if ({WriteEnable, WriteSelect, WriteData} !== 38'h0) begin bad++; $display("FAIL idle_port got=%0h exp=0", {WriteEnable, WriteSelect, WriteData}); end
        ReadSelect2 = 5'd0;
    endtask

    task automatic test_dual();
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBB;
        tick();
        idle();
        total++; if (WriteSelect !== 5'd3 || WriteData !== 32'hAA) begin bad++; $display("FAIL dual_first got=%0h/%0h exp=3/aa", WriteSelect, WriteData); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dual_in_ready got=%0h exp=1", in_ready); end
        tick();
        total++; if (WriteSelect !== 5'd4 || WriteData !== 32'hBB || WriteEnable !== 1'b1) begin bad++; $display("FAIL dual_second got=%0h/%0h exp=4/bb", WriteSelect, WriteData); end
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL dual_drained got=%0h exp=1", empty); end
    endtask

    task automatic test_forward();
        ReadSelect1 = 5'd7; ReadSelect2 = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
        tick();
        total++; if (Fwd1Hit !== 1'b1 || Fwd1Data !== 32'h1) begin bad++; $display("FAIL fwd_first got=%0h/%0h exp=1/1", Fwd1Hit, Fwd1Data); end
        total++; if (Fwd2Hit !== 1'b0 || Fwd2Data !== 32'h0) begin bad++; $display("FAIL fwd_miss got=%0h/%0h exp=0/0", Fwd2Hit, Fwd2Data); end
        alu_data = 32'h2;
        tick();
        idle();
        total++; if (Fwd1Hit !== 1'b1 || Fwd1Data !== 32'h2) begin bad++; $display("FAIL fwd_second got=%0h/%0h exp=1/2", Fwd1Hit, Fwd1Data); end
        tick();
        total++; if (Fwd1Hit !== 1'b0 || Fwd1Data !== 32'h0) begin bad++; $display("FAIL fwd_after_drain got=%0h/%0h exp=0/0", Fwd1Hit, Fwd1Data); end
        // Two pending writes to the same register: youngest (ALU) must win over the head
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h5;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h6;
        tick();
        idle();
        total++; if (Fwd1Data !== 32'h6 || WriteData !== 32'h5) begin bad++; $display("FAIL fwd_youngest got=%0h/%0h exp=6/5", Fwd1Data, WriteData); end
        tick();
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fwd_drained got=%0h exp=1", empty); end
        ReadSelect1 = 5'd0; ReadSelect2 = 5'd0;
    endtask

    task automatic test_rd_zero();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hEE;
        tick();
        idle();
        total++; if (WriteEnable !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL rd_zero got=%0h/%0h exp=0/1", WriteEnable, empty); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rd_zero_overflow got=%0h exp=0", overflow); end
    endtask

    task automatic fill_three();
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h101;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h102;
        tick();
        mem_rd = 5'd3; mem_data = 32'h103;
        alu_rd = 5'd4; alu_data = 32'h104;
        tick();
        idle();
    endtask

    task automatic test_overflow();
        ReadSelect1 = 5'd9;
        fill_three();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovf_in_ready got=%0h exp=0", in_ready); end
        total++; if (full !== 1'b0 || WriteSelect !== 5'd2) begin bad++; $display("FAIL ovf_state got=%0h/%0h exp=0/2", full, WriteSelect); end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        idle();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0h exp=1", overflow); end
        total++; if (WriteSelect !== 5'd3 || Fwd1Hit !== 1'b0) begin bad++; $display("FAIL ovf_dropped got=%0h/%0h exp=3/0", WriteSelect, Fwd1Hit); end
        tick();
        total++; if (WriteSelect !== 5'd4) begin bad++; $display("FAIL ovf_drain got=%0h exp=4", WriteSelect); end
        tick();
        total++; if (empty !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0h/%0h exp=1/1", empty, overflow); end
        ReadSelect1 = 5'd0;
    endtask

    task automatic test_reset_mid();
        fill_three();
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
        tick();
        rst = 1'b0;
        idle();
        total++; if (WriteEnable !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL mid_reset got=%0h/%0h exp=0/1", WriteEnable, empty); end
        total++; if (overflow !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_flags got=%0h/%0h exp=0/1", overflow, in_ready); end
        tick();
        total++; if (WriteEnable !== 1'b0) begin bad++; $display("FAIL mid_reset_nowrite got=%0h exp=0", WriteEnable); end
        // Stream six single entries so head and tail wrap past DEPTH
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'(48 + i);
            tick();
            total++;
            if (WriteSelect !== 5'(10 + i) || WriteData !== 32'(48 + i)) begin
                bad++; $display("FAIL wrap_%0d got=%0h/%0h exp=%0h/%0h", i, WriteSelect, WriteData, 10 + i, 48 + i);
            end
        end
        idle();
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_drained got=%0h exp=1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_forward();
        test_rd_zero();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
